// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and helpers for the raster generator.
// The defaults describe 640x480@60 Hz driven from a 25 MHz pixel rate.
package vga_pkg;

  localparam int COLOR_W = 4;
  localparam int CNT_W   = 10;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // First counter value inside the sync pulse.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // Last counter value inside the sync pulse (inclusive).
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync - 1;
  endfunction

  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_raster_gen_if.sv
// Sprite raster interface: the raster generator (master) presents a scan
// position, the sprite layer (slave) answers with colour and opacity.
//
// Handshake: there is no ready/back-pressure. RASTER_X/RASTER_Y/ACTIVE are
// held stable for a whole pixel period; the slave must settle PIX_* and
// PIX_VALID within that period. PIX_VALID qualifies PIX_* as opaque for the
// presented position and is sampled by the master once per pixel tick.
interface vga_raster_gen_if;
  import vga_pkg::*;

  logic [CNT_W-1:0]   RASTER_X;
  logic [8:0]         RASTER_Y;
  logic               ACTIVE;
  logic [COLOR_W-1:0] PIX_RED;
  logic [COLOR_W-1:0] PIX_GRN;
  logic [COLOR_W-1:0] PIX_BLU;
  logic               PIX_VALID;

  modport master (
    output RASTER_X, RASTER_Y, ACTIVE,
    input  PIX_RED, PIX_GRN, PIX_BLU, PIX_VALID
  );

  modport slave (
    input  RASTER_X, RASTER_Y, ACTIVE,
    output PIX_RED, PIX_GRN, PIX_BLU, PIX_VALID
  );
endinterface

// File: rtl/pixel_tick_div.sv
// Pixel-rate tick generator: one-CLK strobe every CLK_DIV system clocks.
// With CLK_DIV = 1 the strobe is permanently high.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RESET,
  output logic pix_tick
);

  generate
    if (CLK_DIV <= 1) begin : g_bypass
      assign pix_tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(CLK_DIV);
      localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

      logic [DW-1:0] div_cnt;

      // Free-running 0..CLK_DIV-1 counter; the tick marks its last value.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          div_cnt <= '0;
        end else if (div_cnt == LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign pix_tick = (div_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster generator and output stage: scans h/v counters, publishes the
// scan position to the sprite layer, composites the sprite answer over a
// background colour and registers RGB and syncs onto the pins.
module vga_raster_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic               CLK,
  input  logic               RESET,
  vga_raster_gen_if.master   spr,
  input  logic [COLOR_W-1:0] BG_RED,
  input  logic [COLOR_W-1:0] BG_GRN,
  input  logic [COLOR_W-1:0] BG_BLU,
  output logic               VBLANK_START,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_BLANK0 = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));

  logic             pix_tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;
  logic             in_hsync;
  logic             in_vsync;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .CLK      (CLK),
    .RESET    (RESET),
    .pix_tick (pix_tick)
  );

  assign h_wrap   = (h_cnt == H_LAST);
  assign v_wrap   = (v_cnt == V_LAST);
  assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hsync = (h_cnt >= HS_START) && (h_cnt <= HS_END);
  assign in_vsync = (v_cnt >= VS_START) && (v_cnt <= VS_END);

  // Raster position straight from the counter registers: stable per pixel.
  assign spr.RASTER_X = h_cnt;
  assign spr.RASTER_Y = v_cnt[8:0];
  assign spr.ACTIVE   = active;

  // Scan counters: h advances every tick, v advances when h wraps.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Pin stage: colour and syncs for the current position land one tick later,
  // so RGB and syncs stay mutually aligned.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
    end else if (pix_tick) begin
      if (!active) begin
        VGA_R <= '0;
        VGA_G <= '0;
        VGA_B <= '0;
      end else if (spr.PIX_VALID) begin
        VGA_R <= spr.PIX_RED;
        VGA_G <= spr.PIX_GRN;
        VGA_B <= spr.PIX_BLU;
      end else begin
        VGA_R <= BG_RED;
        VGA_G <= BG_GRN;
        VGA_B <= BG_BLU;
      end
      VGA_HS <= !in_hsync;
      VGA_VS <= !in_vsync;
    end
  end

  // One-CLK strobe on the edge that moves the scan to (0, V_ACTIVE).
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      VBLANK_START <= 1'b0;
    end else begin
      VBLANK_START <= pix_tick && h_wrap && (v_cnt == V_BLANK0);
    end
  end

endmodule

// File: doc/vga_raster_gen.md
# vga_raster_gen

Master timing and pixel-output stage for the 640x480@60 Hz VGA display path. Generates the raster scan position (RASTER_X, RASTER_Y) that feeds the sprite layer, samples the returned sprite colour/VALID each pixel, composites it over a background colour, and drives the registered VGA RGB and sync pins. It is the consumer end of the sprite raster interface: sprites answer raster coordinates, this block issues them and uses the answers.

## Interface
Parameters:
- CLK_DIV, 4: system clocks per pixel (100 MHz CLK -> 25 MHz pixel rate); must be >= 1.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels (total 800).
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines (total 525).

Ports:
- CLK  in  1  system clock; one clock domain, all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PIX_RED, PIX_GRN, PIX_BLU  in  4 each  sprite-layer colour for the current raster position.
- PIX_VALID  in  1  sprite-layer pixel is opaque at current raster position.
- BG_RED, BG_GRN, BG_BLU  in  4 each  background colour, sampled every pixel tick.
- RASTER_X  out  10  current horizontal pixel count (h_cnt).
- RASTER_Y  out  9  current line count, low 9 bits of v_cnt.
- ACTIVE  out  1  raster inside 640x480 visible area.
- VBLANK_START  out  1  one-CLK pulse when scan enters line 480, column 0.
- VGA_HS, VGA_VS  out  1 each  negative-polarity syncs.
- VGA_R, VGA_G, VGA_B  out  4 each  registered pixel colour.

## Operation
- Tick divider: counter 0..CLK_DIV-1; pix_tick asserted for one CLK when counter = CLK_DIV-1. CLK_DIV=1 -> pix_tick constantly high.
- h_cnt (10 b) 0..799; increments on pix_tick; wraps 799 -> 0 and advances v_cnt. v_cnt (10 b) 0..524; wraps 524 -> 0 when h_cnt wraps.
- RASTER_X = h_cnt, RASTER_Y = v_cnt[8:0], ACTIVE = (h_cnt < 640) && (v_cnt < 480); all combinational from counter registers, stable for the whole pixel period. Outside ACTIVE, RASTER_* values are don't-care to consumers.
- Compositing, registered on pix_tick: VGA_RGB = !ACTIVE ? 0 : PIX_VALID ? PIX_* : BG_*.
- Syncs, registered on pix_tick from current counters: VGA_HS = !(656 <= h_cnt <= 751); VGA_VS = !(490 <= v_cnt <= 491). Bounds derived from parameters, not literals.
- VBLANK_START: registered, high for exactly one CLK, on the CLK edge where pix_tick moves counters to (h=0, v=480). Sprite-position updates are made in the blanking interval following this pulse.

## Timing
- Reset (RESET low, async): divider=0, h_cnt=0, v_cnt=0, VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VBLANK_START=0. RASTER_X=0, RASTER_Y=0, ACTIVE=1 follow from counters.
- Deassertion: first pix_tick CLK_DIV clocks after RESET rises (first CLK where divider reaches CLK_DIV-1).
- Sprite path is combinational: PIX_* must settle within one pixel period of the RASTER_* change (CLK_DIV-1 multicycle).
- Output latency: colour and syncs for position (h,v) appear on pins one pixel tick after (h,v) is presented; RGB and syncs are therefore mutually aligned.
- Frame = 800 x 525 = 420000 pixel ticks = 1680000 CLK at CLK_DIV=4.
- Simultaneous h and v wrap at (799,524): both counters -> 0 on same tick.
- Reset mid-frame: counters and outputs return immediately to reset values; no partial-frame recovery.

## Structure
- Package vga_pkg: default timing constants (H_*/V_*), derived H_TOTAL/V_TOTAL, sync start/end, colour width (4).
- Sub-module pixel_tick_div: divider producing pix_tick; remainder (counters, sync decode, compositor, output registers) in vga_raster_gen.

## Test plan
- Reset release, CLK_DIV=4: pix_tick every 4th CLK; VGA_HS falls exactly 656 ticks after first tick, low 96 ticks; period 800 ticks.
- Full frame: VGA_VS low for 2 lines starting line 490; VBLANK_START pulses once per 1680000 CLK, each one CLK wide, when RASTER_Y=480, RASTER_X=0.
- Compositing: BG=0x3,0x3,0x3; PIX_VALID high only for RASTER_X 100..139, RASTER_Y 50..89, PIX=0xF,0x0,0x0 -> pins show red exactly in that 40x40 box one tick later, 0x333 elsewhere visible, 000 in blanking.
- Blanking suppression: PIX_VALID=1, PIX=0xFFF constant -> VGA_RGB=0 whenever h>=640 or v>=480.
- Wrap: at (799,524) next tick gives RASTER_X=0, RASTER_Y=0, ACTIVE=1.
- Async reset mid-line (h=300, v=200): outputs reach reset values without a CLK edge; counting restarts from (0,0).
